serial_word_cmp: RTL and testbench

//  Bit-serial word comparator: receives two WIDTH-bit operands one bit-pair per

---
 rtl/serial_word_cmp.sv | 182 ++++++++++++++++++
 tb/tb_serial_word_cmp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_cmp.sv
// ---------------------------------------------------------------------------
// serial_word_cmp
//
// Bit-serial word comparator. Two WIDTH-bit operands arrive one bit-pair per
// accepted beat, most significant bit first. Once WIDTH pairs have been
// accepted, the equality verdict is presented on a valid/ready result port.
// If magnitude support is built in, the greater/less verdicts are presented
// there as well.
//
// Build option:
//   CMP_MAG_EN  when defined, adds gt/lt accumulators and the res_gt/res_lt
//               ports. When undefined, only equality is computed.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   clr        synchronous abort of a partial compare or a pending result
//   bit_valid  a bit-pair is offered
//   bit_ready  block can accept a bit-pair (COLLECT state, out of reset)
//   bit_a      operand A bit, MSB first
//   bit_b      operand B bit, MSB first
//   bit_cnt    bit-pairs accepted in the current compare
//   res_valid  result available
//   res_ready  consumer takes the result
//   res_eq     A == B
//   res_gt     A > B  (CMP_MAG_EN only)
//   res_lt     A < B  (CMP_MAG_EN only)
// ---------------------------------------------------------------------------
module serial_word_cmp #(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       bit_valid,
   output logic                       bit_ready,
   input  logic                       bit_a,
   input  logic                       bit_b,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       res_eq
`ifdef CMP_MAG_EN
   ,
   output logic                       res_gt,
   output logic                       res_lt
`endif
);

   localparam int CNT_W = $clog2(WIDTH+1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

   typedef enum logic {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
   logic             eqAcc_q, eqAcc_d;
   logic             resEq_q, resEq_d;
`ifdef CMP_MAG_EN
   logic             gtAcc_q, gtAcc_d;
   logic             ltAcc_q, ltAcc_d;
   logic             resGt_q, resGt_d;
   logic             resLt_q, resLt_d;
`endif
   logic             accept;

   // bit_ready is gated by rst_n, so no pair is taken while reset is asserted.
   // It rises in the first cycle after release because state is already COLLECT.
   assign bit_ready = rst_n & (state_q == COLLECT);
   assign accept    = bit_valid & bit_ready;
   assign res_valid = (state_q == RESULT);
   assign bit_cnt   = bitCnt_q;
   assign res_eq    = resEq_q;
`ifdef CMP_MAG_EN
   assign res_gt    = resGt_q;
   assign res_lt    = resLt_q;
`endif

   // Next-state logic.
   // clr takes priority over both a bit accept and a result handshake.
   // On the last accepted pair, the updated accumulators are copied straight
   // into the result registers, so the verdict appears one cycle after that
   // pair is accepted.
   // The magnitude verdict is decided by the first mismatching pair. That pair
   // is identified by eqAcc_q still being set when the mismatch arrives.
   // While a result is held, bit_cnt shows WIDTH, the number of pairs that
   // went into that result.
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      eqAcc_d  = eqAcc_q;
      resEq_d  = resEq_q;
`ifdef CMP_MAG_EN
      gtAcc_d  = gtAcc_q;
      ltAcc_d  = ltAcc_q;
      resGt_d  = resGt_q;
      resLt_d  = resLt_q;
`endif
      if (clr) begin
         state_d  = COLLECT;
         bitCnt_d = '0;
         eqAcc_d  = 1'b1;
`ifdef CMP_MAG_EN
         gtAcc_d  = 1'b0;
         ltAcc_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  eqAcc_d = eqAcc_q & ~(bit_a ^ bit_b);
`ifdef CMP_MAG_EN
                  if (eqAcc_q && bit_a && !bit_b) begin
                     gtAcc_d = 1'b1;
                  end
                  if (eqAcc_q && !bit_a && bit_b) begin
                     ltAcc_d = 1'b1;
                  end
`endif
                  if (bitCnt_q == LAST_IDX) begin
                     state_d  = RESULT;
                     bitCnt_d = FULL_CNT;
                     resEq_d  = eqAcc_d;
`ifdef CMP_MAG_EN
                     resGt_d  = gtAcc_d;
                     resLt_d  = ltAcc_d;
`endif
                  end else begin
                     bitCnt_d = bitCnt_q + 1'b1;
                  end
               end
            end
            RESULT: begin
               if (res_ready) begin
                  state_d  = COLLECT;
                  bitCnt_d = '0;
                  eqAcc_d  = 1'b1;
`ifdef CMP_MAG_EN
                  gtAcc_d  = 1'b0;
                  ltAcc_d  = 1'b0;
`endif
               end
            end
            default: begin
               state_d = COLLECT;
            end
         endcase
      end
   end

   // State and data registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         bitCnt_q <= '0;
         eqAcc_q  <= 1'b1;
         resEq_q  <= 1'b0;
`ifdef CMP_MAG_EN
         gtAcc_q  <= 1'b0;
         ltAcc_q  <= 1'b0;
         resGt_q  <= 1'b0;
         resLt_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         eqAcc_q  <= eqAcc_d;
         resEq_q  <= resEq_d;
`ifdef CMP_MAG_EN
         gtAcc_q  <= gtAcc_d;
         ltAcc_q  <= ltAcc_d;
         resGt_q  <= resGt_d;
         resLt_q  <= resLt_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_word_cmp.sv
// ---------------------------------------------------------------------------
// tb_serial_word_cmp
//
// Directed bench for serial_word_cmp with WIDTH=4.
// Expected verdicts are computed from the whole operands when a compare is
// driven, and pushed to a scoreboard queue. They are popped and compared
// when the DUT presents a result.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge before the next drive.
// ---------------------------------------------------------------------------
module tb_serial_word_cmp;

   localparam int W     = 4;
   localparam int CNT_W = $clog2(W+1);

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             bit_valid;
   logic             bit_ready;
   logic             bit_a;
   logic             bit_b;
   logic [CNT_W-1:0] bit_cnt;
   logic             res_valid;
   logic             res_ready;
   logic             res_eq;
`ifdef CMP_MAG_EN
   logic             res_gt;
   logic             res_lt;
`endif

   exp_t sb[$];
   exp_t lastExp;
   int   checks = 0;
   int   errors = 0;

   serial_word_cmp #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_a     (bit_a),
      .bit_b     (bit_b),
      .bit_cnt   (bit_cnt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_eq    (res_eq)
`ifdef CMP_MAG_EN
      ,
      .res_gt    (res_gt),
      .res_lt    (res_lt)
`endif
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog, so that a stuck run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one observed value with its expected value and counts failures.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advances one full clock cycle, from falling edge to falling edge.
   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Offers one bit-pair for a single cycle.
   task automatic applyStimulus(input logic a, input logic b);
      bit_valid = 1'b1;
      bit_a     = a;
      bit_b     = b;
      @(posedge clk);
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   // Sends a full word MSB first. Where gaps[i] is set, two idle cycles are
   // inserted before bit i.
   task automatic compareWord(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] gaps);
      exp_t e;
      e.eq = (a == b);
      e.gt = (a > b);
      e.lt = (a < b);
      sb.push_back(e);
      for (int i = W-1; i >= 0; i--) begin
         if (gaps[i]) idleCycles(2);
         applyStimulus(a[i], b[i]);
         if (i != 0) checkOutput("bit_cnt_progress", 32'(bit_cnt), 32'(W-i));
      end
      checkOutput("result_latency", 32'(res_valid), 32'd1);
   endtask

   // Waits a bounded number of cycles for a result, then checks it against
   // the scoreboard.
   task automatic collectResult();
      int n = 0;
      while (!res_valid && n < 20) begin
         idleCycles(1);
         n++;
      end
      checkOutput("result_wait", 32'(res_valid), 32'd1);
      checkOutput("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         lastExp = sb.pop_front();
         checkOutput("res_eq", 32'(res_eq), 32'(lastExp.eq));
`ifdef CMP_MAG_EN
         checkOutput("res_gt", 32'(res_gt), 32'(lastExp.gt));
         checkOutput("res_lt", 32'(res_lt), 32'(lastExp.lt));
`endif
      end
   endtask

   // Takes the result and checks the return to COLLECT.
   task automatic handshake();
      res_ready = 1'b1;
      idleCycles(1);
      res_ready = 1'b0;
      checkOutput("post_hs_res_valid", 32'(res_valid), 32'd0);
      checkOutput("post_hs_bit_ready", 32'(bit_ready), 32'd1);
      checkOutput("post_hs_bit_cnt", 32'(bit_cnt), 32'd0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst_n     = 1'b0;
      clr       = 1'b0;
      bit_valid = 1'b0;
      bit_a     = 1'b0;
      bit_b     = 1'b0;
      res_ready = 1'b0;

      // Reset is held for two cycles. bit_ready must stay low throughout.
      @(negedge clk);
      checkOutput("reset_bit_ready", 32'(bit_ready), 32'd0);
      idleCycles(1);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset_res_eq", 32'(res_eq), 32'd0);
      checkOutput("reset_bit_cnt", 32'(bit_cnt), 32'd0);
      checkOutput("reset_bit_ready", 32'(bit_ready), 32'd1);
`ifdef CMP_MAG_EN
      checkOutput("reset_res_gt", 32'(res_gt), 32'd0);
      checkOutput("reset_res_lt", 32'(res_lt), 32'd0);
`endif
      @(negedge clk);

      // Equal operands sent on back-to-back beats.
      $display("[TB] equal operands 1011/1011");
      compareWord(4'b1011, 4'b1011, 4'b0000);
      collectResult();
      handshake();

      // Greater-than case, followed by a held result.
      $display("[TB] 1011/1001 with result held for 5 cycles");
      compareWord(4'b1011, 4'b1001, 4'b0000);
      collectResult();
      for (int k = 0; k < 5; k++) begin
         bit_valid = 1'b1;
         bit_a     = 1'b1;
         bit_b     = 1'b1;
         idleCycles(1);
         checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
         checkOutput("hold_bit_ready", 32'(bit_ready), 32'd0);
         checkOutput("hold_res_eq", 32'(res_eq), 32'(lastExp.eq));
`ifdef CMP_MAG_EN
         checkOutput("hold_res_gt", 32'(res_gt), 32'(lastExp.gt));
`endif
      end
      bit_valid = 1'b0;
      handshake();
      compareWord(4'b0000, 4'b0000, 4'b0000);
      collectResult();
      handshake();

      // Less-than case.
      $display("[TB] less-than operands 0110/0111");
      compareWord(4'b0110, 4'b0111, 4'b0000);
      collectResult();
      handshake();

      // Abort a partial compare. The pair offered alongside clr is dropped.
      $display("[TB] clr during partial compare");
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("clr_pre_bit_cnt", 32'(bit_cnt), 32'd2);
      clr       = 1'b1;
      bit_valid = 1'b1;
      bit_a     = 1'b1;
      bit_b     = 1'b0;
      idleCycles(1);
      clr       = 1'b0;
      bit_valid = 1'b0;
      checkOutput("clr_bit_cnt", 32'(bit_cnt), 32'd0);
      checkOutput("clr_res_valid", 32'(res_valid), 32'd0);
      compareWord(4'b1111, 4'b1111, 4'b0000);
      collectResult();
      handshake();

      // clr together with a result handshake discards the result.
      $display("[TB] clr with pending result");
      compareWord(4'b1100, 4'b0011, 4'b0000);
      clr       = 1'b1;
      res_ready = 1'b1;
      idleCycles(1);
      clr       = 1'b0;
      res_ready = 1'b0;
      void'(sb.pop_front());
      checkOutput("clr_discard_res_valid", 32'(res_valid), 32'd0);
      checkOutput("clr_discard_bit_ready", 32'(bit_ready), 32'd1);
      checkOutput("clr_discard_bit_cnt", 32'(bit_cnt), 32'd0);

      // Beats separated by gaps.
      $display("[TB] gapped beats 0101/0101");
      compareWord(4'b0101, 4'b0101, 4'b0110);
      collectResult();
      handshake();

      // A few pseudo-random operand pairs. The first pair is forced equal.
      for (int k = 0; k < 4; k++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = (k == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
         compareWord(ra, rb, 4'b0000);
         collectResult();
         handshake();
      end

      // Reset mid-compare: the partial word is lost.
      $display("[TB] reset after 3 beats");
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("max_bit_cnt", 32'(bit_cnt), 32'(W-1));
      rst_n = 1'b0;
      idleCycles(1);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset_res_valid", 32'(res_valid), 32'd0);
      checkOutput("midreset_bit_cnt", 32'(bit_cnt), 32'd0);
      checkOutput("midreset_bit_ready", 32'(bit_ready), 32'd1);
      @(negedge clk);
      idleCycles(3);
      checkOutput("midreset_no_result", 32'(res_valid), 32'd0);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
